// File: rtl/inv_sub_bytes_iter_if.sv
// inv_sub_bytes_iter_if: request/ready handshake and state bus between InvShiftRows, InvSubBytes and AddRoundKey.
interface inv_sub_bytes_iter_if;
   logic ClkEn;
   logic [127:0] data;
   logic [127:0] dataOut;
   logic Ry;
   modport master (output ClkEn, data, input dataOut, Ry);
   modport slave (input ClkEn, data, output dataOut, Ry);
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes, LANES inverse S-box lookups per cycle over a 128-bit state.
module inv_sub_bytes_iter #(
   parameter int LANES = 4
) (
   input logic Clk,
   input logic Rst,
   inv_sub_bytes_iter_if.slave bus
);
   localparam int GROUPS = 16 / LANES;
   localparam int IW = GROUPS > 1 ? $clog2(GROUPS) : 1;
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
   stateT state, nextState;
   logic [IW-1:0] idx;
   logic [127:0] workBuf, nextBuf;
   logic lastGroup;
   int base, pos;
   assign lastGroup = idx == IW'(GROUPS - 1);
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else state <= nextState;
   end
   // Dropping ClkEn in BUSY wins over completion, even on the last group.
   always_comb begin
      nextState = state == IDLE ? (bus.ClkEn ? BUSY : IDLE) :
                  !bus.ClkEn ? IDLE :
                  (state == BUSY && !lastGroup) ? BUSY : DONE;
   end
   // Byte 0 sits in the top byte, so byte n lives at bit offset (15-n)*8.
   always_comb begin
      nextBuf = workBuf;
      base = int'(idx) * LANES;
      pos = 0;
      for (int g = 0; g < LANES; g++) begin
         pos = 15 - base - g;
         nextBuf[pos*8 +: 8] = INV_SBOX[workBuf[pos*8 +: 8]];
      end
   end
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         idx <= '0;
         workBuf <= '0;
         bus.dataOut <= '0;
      end else if (state == IDLE && bus.ClkEn) begin
         workBuf <= bus.data;
         idx <= '0;
      end else if (state == BUSY) begin
         idx <= (bus.ClkEn && !lastGroup) ? idx + 1'b1 : '0;
         if (bus.ClkEn) workBuf <= nextBuf;
         if (bus.ClkEn && lastGroup) bus.dataOut <= nextBuf;
      end
   end
   always_comb begin
      bus.Ry = state == DONE;
   end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: scoreboard bench driving LANES=1/4/16 instances with identical requests.
module tb_inv_sub_bytes_iter;
   logic Clk = 0;
   logic Rst = 1;
   always #5 Clk = ~Clk;
   inv_sub_bytes_iter_if b0();
   inv_sub_bytes_iter_if b1();
   inv_sub_bytes_iter_if b2();
   inv_sub_bytes_iter #(.LANES(1)) u0 (.Clk(Clk), .Rst(Rst), .bus(b0));
   inv_sub_bytes_iter #(.LANES(4)) u1 (.Clk(Clk), .Rst(Rst), .bus(b1));
   inv_sub_bytes_iter #(.LANES(16)) u2 (.Clk(Clk), .Rst(Rst), .bus(b2));
   typedef struct {logic [127:0] d; logic [2:0] m;} expT;
   expT expQ[$];
   int rdPtr[3] = '{0, 0, 0};
   int nChecks = 0, nFails = 0;
   int cyc = 0, reqCyc = 0;
   logic ceAtEdge = 0;
   localparam int LAT [3] = '{16, 4, 1};
   logic ry[3];
   logic [127:0] dout[3];
   logic prevRy[3] = '{0, 0, 0};
   logic [127:0] lastOut[3] = '{default: '0};
   assign ry[0] = b0.Ry;
   assign ry[1] = b1.Ry;
   assign ry[2] = b2.Ry;
   assign dout[0] = b0.dataOut;
   assign dout[1] = b1.dataOut;
   assign dout[2] = b2.dataOut;
   localparam logic [127:0] KNOWN_IN = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] KNOWN_OUT = 128'h000102030405060708090a0b0c0d0e0f;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic ce, input logic [127:0] d);
      b0.ClkEn = ce; b1.ClkEn = ce; b2.ClkEn = ce;
      b0.data = d; b1.data = d; b2.data = d;
   endtask
   // Holds ClkEn for `hold` sampling edges; data is scrambled after the first edge.
   task automatic request(input logic [127:0] d, input logic [127:0] exp, input logic [2:0] m, input int hold);
      @(negedge Clk);
      drive(1'b1, d);
      reqCyc = cyc + 1;
      expQ.push_back('{exp, m});
      @(negedge Clk);
      drive(1'b1, ~d);
      repeat (hold - 1) @(negedge Clk);
      drive(1'b0, d ^ 128'h5a5a);
      repeat (2) @(negedge Clk);
   endtask
   always @(posedge Clk) begin
      cyc <= cyc + 1;
      ceAtEdge <= b1.ClkEn;
   end
   always @(negedge Clk) begin
      int k;
      if (Rst) begin
         for (int i = 0; i < 3; i++) begin
            prevRy[i] <= 1'b0;
            lastOut[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!ceAtEdge) chk($sformatf("ry_after_drop_L%0d", 16 / LAT[i]), 128'(ry[i]), 128'(0));
            if (ry[i] && !prevRy[i]) begin
               k = rdPtr[i];
               while (k < expQ.size() && !expQ[k].m[i]) k++;
               if (k >= expQ.size()) begin
                  nChecks++;
                  nFails++;
                  $display("FAIL unexpected_ry_L%0d: got Ry=1 dataOut=%h, expected no result", 16 / LAT[i], dout[i]);
               end else begin
                  chk($sformatf("result_L%0d", 16 / LAT[i]), dout[i], expQ[k].d);
                  chk($sformatf("latency_L%0d", 16 / LAT[i]), 128'(cyc - reqCyc), 128'(LAT[i]));
                  k++;
               end
               rdPtr[i] <= k;
               lastOut[i] <= dout[i];
            end else begin
               chk($sformatf("hold_L%0d", 16 / LAT[i]), dout[i], lastOut[i]);
            end
            prevRy[i] <= ry[i];
         end
      end
   end
   initial begin
      int k;
      drive(1'b0, '0);
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_data_L%0d", 16 / LAT[i]), dout[i], '0);
         chk($sformatf("reset_ry_L%0d", 16 / LAT[i]), 128'(ry[i]), 128'(0));
      end
      @(posedge Clk) #2 Rst = 0;
      request(KNOWN_IN, KNOWN_OUT, 3'b111, 26);
      request('0, {16{8'h52}}, 3'b111, 26);
      request({16{8'h16}}, {16{8'hff}}, 3'b111, 26);
      request(128'hca82c97dfa5947f0add4a2af9ca472c0, 128'h101112131415161718191a1b1c1d1e1f, 3'b111, 26);
      request('0, {16{8'h52}}, 3'b100, 3);
      @(negedge Clk);
      drive(1'b1, {16{8'hff}});
      reqCyc = cyc + 1;
      expQ.push_back('{{16{8'h7d}}, 3'b100});
      repeat (3) @(posedge Clk);
      #3 Rst = 1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("midbusy_reset_data_L%0d", 16 / LAT[i]), dout[i], '0);
         chk($sformatf("midbusy_reset_ry_L%0d", 16 / LAT[i]), 128'(ry[i]), 128'(0));
      end
      @(negedge Clk);
      drive(1'b0, '0);
      @(posedge Clk) #2 Rst = 0;
      repeat (3) @(negedge Clk);
      request(KNOWN_IN, KNOWN_OUT, 3'b111, 26);
      repeat (3) @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
         k = rdPtr[i];
         while (k < expQ.size() && !expQ[k].m[i]) k++;
         chk($sformatf("drain_L%0d", 16 / LAT[i]), 128'(k), 128'(expQ.size()));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
